// File: rtl/uart_tx_fsm_pkg.sv
// uart_tx_pkg: shared types and line-level constants for the UART transmit
// frame controller.
//   state_e      frame sequencer states
//   PAR_EVEN/ODD encoding of the par_typ input
//   *_LEVEL      line levels for idle, start and stop bits
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_fsm_if.sv
// uart_tx_fsm_if: byte-source and serializer connections of the UART frame
// controller.
//   p_data, data_valid, par_en, par_typ : byte request from the source
//   busy, frame_done                    : status back to the source
//   ser_data                            : current bit from the serializer
//   ser_load, ser_en                    : serializer capture / advance
//   tx_out                              : serial line
// modport master: source + serializer side; modport slave: frame controller.
interface uart_tx_fsm_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_en;
   logic                  par_typ;
   logic                  ser_data;
   logic                  ser_load;
   logic                  ser_en;
   logic                  tx_out;
   logic                  busy;
   logic                  frame_done;

   modport master (
      output p_data, data_valid, par_en, par_typ, ser_data,
      input  ser_load, ser_en, tx_out, busy, frame_done
   );

   modport slave (
      input  p_data, data_valid, par_en, par_typ, ser_data,
      output ser_load, ser_en, tx_out, busy, frame_done
   );
endinterface

// File: rtl/uart_tx_fsm_parity_calc.sv
// parity_calc: combinational parity bit for one data word.
//   data    in  DATA_WIDTH  word to cover
//   par_typ in  1           PAR_EVEN or PAR_ODD
//   par_bit out 1           bit that makes the total count of ones even/odd
module parity_calc
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  par_bit
);

   // Odd parity is the inverted reduction XOR.
   assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: frame controller for the UART transmitter. Accepts a byte on
// data_valid while idle, loads the external serializer, then drives the
// registered line with start bit, LSB-first data, optional parity and
// STOP_BITS stop bits.
//   clk  in  bit clock (one line bit per cycle)
//   rst  in  synchronous active-high reset
//   bus  uart_tx_fsm_if.slave (source request/status, serializer, tx_out)
module uart_tx_fsm
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1,
   parameter int CNT_WIDTH  = 4
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_fsm_if.slave  bus
);

   localparam logic [CNT_WIDTH-1:0] LAST_DATA = CNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] LAST_STOP = CNT_WIDTH'(STOP_BITS - 1);

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  tx_out_q, tx_out_d;
   logic                  busy_q, busy_d;
   logic                  frame_done_q, frame_done_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_bit;
   logic                  ser_load_c;
   logic                  ser_en_c;

   // Parity comes from the byte latched at acceptance, so the serializer
   // state and later input changes cannot affect it.
   parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .data    (data_q),
      .par_typ (par_typ_q),
      .par_bit (par_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         tx_out_q     <= IDLE_LEVEL;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         par_en_q     <= 1'b0;
         par_typ_q    <= PAR_EVEN;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         tx_out_q     <= tx_out_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         par_en_q     <= par_en_d;
         par_typ_q    <= par_typ_d;
      end
      data_q <= data_d;
   end

   // tx_out_d is the line level for the state being entered, so the line
   // register always shows the bit belonging to the current state.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      tx_out_d     = tx_out_q;
      frame_done_d = 1'b0;
      par_en_d     = par_en_q;
      par_typ_d    = par_typ_q;
      data_d       = data_q;
      ser_load_c   = 1'b0;
      ser_en_c     = 1'b0;

      case (state_q)
         IDLE: begin
            tx_out_d = IDLE_LEVEL;
            if (bus.data_valid && !rst) begin
               ser_load_c = 1'b1;
               par_en_d   = bus.par_en;
               par_typ_d  = bus.par_typ;
               data_d     = bus.p_data;
               state_d    = START;
               tx_out_d   = START_LEVEL;
            end
         end
         START: begin
            // Serializer already shows bit 0; capture it and step to bit 1.
            ser_en_c = 1'b1;
            cnt_d    = '0;
            state_d  = DATA;
            tx_out_d = bus.ser_data;
         end
         DATA: begin
            if (cnt_q == LAST_DATA) begin
               if (par_en_q) begin
                  state_d  = PARITY;
                  tx_out_d = par_bit;
               end else begin
                  state_d  = STOP;
                  cnt_d    = '0;
                  tx_out_d = STOP_LEVEL;
               end
            end else begin
               ser_en_c = 1'b1;
               cnt_d    = cnt_q + 1'b1;
               tx_out_d = bus.ser_data;
            end
         end
         PARITY: begin
            state_d  = STOP;
            cnt_d    = '0;
            tx_out_d = STOP_LEVEL;
         end
         STOP: begin
            if (cnt_q == LAST_STOP) begin
               state_d      = IDLE;
               tx_out_d     = IDLE_LEVEL;
               frame_done_d = 1'b1;
            end else begin
               cnt_d    = cnt_q + 1'b1;
               tx_out_d = STOP_LEVEL;
            end
         end
         default: begin
            state_d  = IDLE;
            tx_out_d = IDLE_LEVEL;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // Serializer strobes are forced low while reset is asserted.
   assign bus.ser_load   = ser_load_c;
   assign bus.ser_en     = ser_en_c & ~rst;
   assign bus.tx_out     = tx_out_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: directed self-checking bench for uart_tx_fsm. Two DUTs share
// the stimulus: dut1 with one stop bit, dut2 with two stop bits. Each has a
// small serializer model. Expected line patterns are hand-computed constants
// {stop bits, [parity], byte, start}, bit 0 = cycle 1.
module tb_uart_tx_fsm;

   logic       clk;
   logic       rst;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_en;
   logic       par_typ;
   logic       sel;
   int         checks;
   int         failures;
   int         loads1;
   int         loads_before;

   uart_tx_fsm_if #(.DATA_WIDTH(8)) if1 ();
   uart_tx_fsm_if #(.DATA_WIDTH(8)) if2 ();

   uart_tx_fsm #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(4)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   uart_tx_fsm #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(4)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (if2)
   );

   assign if1.p_data     = p_data;
   assign if1.data_valid = data_valid;
   assign if1.par_en     = par_en;
   assign if1.par_typ    = par_typ;
   assign if2.p_data     = p_data;
   assign if2.data_valid = data_valid;
   assign if2.par_en     = par_en;
   assign if2.par_typ    = par_typ;

   // Serializer models: capture on ser_load, advance on ser_en.
   logic [7:0] sb1 = '0;
   logic [7:0] sb2 = '0;
   logic [3:0] si1 = '0;
   logic [3:0] si2 = '0;

   always_ff @(posedge clk) begin
      if (if1.ser_load) begin
         sb1 <= if1.p_data;
         si1 <= '0;
      end else if (if1.ser_en) begin
         si1 <= si1 + 4'd1;
      end
      if (if2.ser_load) begin
         sb2 <= if2.p_data;
         si2 <= '0;
      end else if (if2.ser_en) begin
         si2 <= si2 + 4'd1;
      end
      if (if1.ser_load) loads1 <= loads1 + 1;
   end

   assign if1.ser_data = (si1 < 4'd8) ? sb1[si1[2:0]] : 1'b0;
   assign if2.ser_data = (si2 < 4'd8) ? sb2[si2[2:0]] : 1'b0;

   logic s_tx, s_busy, s_done, s_load, s_en;
   assign s_tx   = sel ? if2.tx_out     : if1.tx_out;
   assign s_busy = sel ? if2.busy       : if1.busy;
   assign s_done = sel ? if2.frame_done : if1.frame_done;
   assign s_load = sel ? if2.ser_load   : if1.ser_load;
   assign s_en   = sel ? if2.ser_en     : if1.ser_en;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout observed=running required=finished");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starting at +1 of cycle 1, checks cycles 1..nbits of a frame.
   task automatic check_line(input string tag, input logic [15:0] exp_line,
                             input int nbits, input logic [15:0] dv_mask);
      for (int c = 1; c <= nbits; c++) begin
         data_valid = dv_mask[c];
         #4;
         chk($sformatf("%s_tx%0d", tag, c), 16'(s_tx), 16'(exp_line[c-1]));
         chk($sformatf("%s_busy%0d", tag, c), 16'(s_busy), 16'd1);
         chk($sformatf("%s_done%0d", tag, c), 16'(s_done), 16'd0);
         chk($sformatf("%s_load%0d", tag, c), 16'(s_load), 16'd0);
         step();
      end
   endtask

   task automatic frame(input string tag, input logic [7:0] d, input logic pe,
                        input logic pt, input logic [15:0] exp_line,
                        input int nbits, input logic [15:0] dv_mask);
      p_data     = d;
      par_en     = pe;
      par_typ    = pt;
      data_valid = 1'b1;
      #4;
      chk({tag, "_accept_load"}, 16'(s_load), 16'd1);
      chk({tag, "_accept_busy"}, 16'(s_busy), 16'd0);
      step();
      // Changing the request fields mid-frame must not affect this frame.
      p_data  = ~d;
      par_en  = ~pe;
      par_typ = ~pt;
      check_line(tag, exp_line, nbits, dv_mask);
      data_valid = 1'b0;
      #4;
      chk({tag, "_done"}, 16'(s_done), 16'd1);
      chk({tag, "_done_busy"}, 16'(s_busy), 16'd0);
      chk({tag, "_done_tx"}, 16'(s_tx), 16'd1);
      step();
      #4;
      chk({tag, "_done_pulse"}, 16'(s_done), 16'd0);
      step();
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      loads1     = 0;
      sel        = 1'b0;
      rst        = 1'b1;
      data_valid = 1'b1;
      p_data     = 8'hFF;
      par_en     = 1'b0;
      par_typ    = 1'b0;

      // Reset held with data_valid high: nothing may be accepted.
      step();
      step();
      #4;
      chk("rst_load1", 16'(if1.ser_load), 16'd0);
      chk("rst_en1", 16'(if1.ser_en), 16'd0);
      chk("rst_tx1", 16'(if1.tx_out), 16'd1);
      chk("rst_busy1", 16'(if1.busy), 16'd0);
      chk("rst_done1", 16'(if1.frame_done), 16'd0);
      chk("rst_tx2", 16'(if2.tx_out), 16'd1);
      chk("rst_busy2", 16'(if2.busy), 16'd0);
      step();
      rst        = 1'b0;
      data_valid = 1'b0;
      #4;
      chk("post_rst_busy", 16'(if1.busy), 16'd0);
      chk("post_rst_tx", 16'(if1.tx_out), 16'd1);
      step();

      // Plain and parity frames on the one-stop-bit DUT.
      frame("a5_np", 8'hA5, 1'b0, 1'b0, 16'h034A, 10, 16'h0000);
      step();
      frame("a5_even", 8'hA5, 1'b1, 1'b0, 16'h054A, 11, 16'h0000);
      step();
      frame("01_odd", 8'h01, 1'b1, 1'b1, 16'h0402, 11, 16'h0000);
      step();
      frame("01_even", 8'h01, 1'b1, 1'b0, 16'h0602, 11, 16'h0000);
      step();

      // Two stop bits: line high on cycles 10 and 11, busy for 11 cycles.
      sel = 1'b1;
      frame("ff_2stop", 8'hFF, 1'b0, 1'b0, 16'h07FE, 11, 16'h0000);
      sel = 1'b0;
      step();
      step();

      // data_valid pulsed at cycles 3 and 8 while busy is ignored.
      loads_before = loads1;
      frame("dv_ign", 8'hA5, 1'b0, 1'b0, 16'h034A, 10, 16'h0108);
      chk("dv_ign_loads", 16'(loads1 - loads_before), 16'd1);
      step();

      // Reset at cycle 5 of a 0x3C frame, then a fresh 0x55 frame.
      p_data     = 8'h3C;
      par_en     = 1'b0;
      data_valid = 1'b1;
      #4;
      chk("3c_accept", 16'(s_load), 16'd1);
      step();
      data_valid = 1'b0;
      check_line("3c", 16'h0278, 4, 16'h0000);
      rst = 1'b1;
      #4;
      chk("3c_rst_en", 16'(if1.ser_en), 16'd0);
      chk("3c_rst_load", 16'(if1.ser_load), 16'd0);
      step();
      rst = 1'b0;
      #4;
      chk("3c_abort_tx", 16'(if1.tx_out), 16'd1);
      chk("3c_abort_busy", 16'(if1.busy), 16'd0);
      chk("3c_abort_done", 16'(if1.frame_done), 16'd0);
      chk("3c_abort_en", 16'(if1.ser_en), 16'd0);
      chk("3c_abort_load", 16'(if1.ser_load), 16'd0);
      step();
      frame("55_after_rst", 8'h55, 1'b0, 1'b0, 16'h02AA, 10, 16'h0000);
      step();
      step();

      // Back-to-back with data_valid held high: 0x12 then 0x34.
      p_data     = 8'h12;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      data_valid = 1'b1;
      #4;
      chk("b2b_accept1", 16'(s_load), 16'd1);
      step();
      p_data = 8'h34;
      check_line("b2b_12", 16'h0224, 10, 16'hFFFF);
      #4;
      chk("b2b_done1", 16'(s_done), 16'd1);
      chk("b2b_accept2", 16'(s_load), 16'd1);
      chk("b2b_gap_busy", 16'(s_busy), 16'd0);
      chk("b2b_gap_tx", 16'(s_tx), 16'd1);
      step();
      data_valid = 1'b0;
      check_line("b2b_34", 16'h0268, 10, 16'h0000);
      #4;
      chk("b2b_done2", 16'(s_done), 16'd1);
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Frame controller for the UART transmitter. It accepts a byte on a valid strobe and loads it into the serializer, then sequences start bit, serializer data bits, optional parity bit and stop bit(s) onto the line. It drives the line register directly and exposes `busy` to the upstream source. It sits between the byte source and the serializer, and owns the `tx_out` pin.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.
- `CNT_WIDTH`, 4: bit-counter width; must hold `DATA_WIDTH-1`.

Clocking and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  bit clock (one line bit per cycle)
- `rst`  in  1  synchronous reset
- `p_data`  in  DATA_WIDTH  byte to send; sampled on acceptance
- `data_valid`  in  1  request; accepted only in IDLE
- `par_en`  in  1  parity bit enable; sampled on acceptance
- `par_typ`  in  1  0 = even, 1 = odd; sampled on acceptance
- `ser_data`  in  1  serializer current bit (combinational from serializer index)
- `ser_load`  out  1  combinational; serializer captures `p_data` and zeroes its index
- `ser_en`  out  1  combinational; serializer advances its index at this edge
- `tx_out`  out  1  registered line output; idle high
- `busy`  out  1  registered; high from start bit through last stop bit
- `frame_done`  out  1  registered one-cycle pulse after the last stop bit

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx_out` = 1, `busy` = 0.
  - If `data_valid` = 1: assert `ser_load`; latch `par_en`, `par_typ` and parity of `p_data`; go to START.
- START:
  - `tx_out` = 0.
  - Assert `ser_en`, clear the bit counter, go to DATA.
- DATA:
  - `tx_out` carries the `ser_data` value registered on entry; LSB first.
  - `ser_en` = 1 while counter < `DATA_WIDTH-1`.
  - On counter = `DATA_WIDTH-1`: go to PARITY if latched `par_en`, else STOP.
- PARITY:
  - `tx_out` = `^data` for even, `~^data` for odd.
  - Go to STOP.
- STOP:
  - `tx_out` = 1 for `STOP_BITS` cycles; the counter is reused.
  - Then go to IDLE and pulse `frame_done`.
- Arithmetic:
  - Parity is computed from the latched byte, never from `ser_data`.
  - The counter saturates only through state exit; no wrap is used.
- Boundary conditions:
  - `data_valid` while `busy` = 1 is ignored. There is no queue and no error flag.
  - `par_en`/`par_typ` changes mid-frame have no effect on the current frame.
  - Minimum one IDLE cycle between frames.
  - `rst` mid-frame: next cycle is IDLE with `tx_out` = 1, `busy` = 0, `frame_done` = 0, and `ser_en`/`ser_load` = 0. The aborted frame is not resumed.
  - `rst` together with `data_valid`: reset wins and nothing is accepted.
- Reset values: `tx_out` = 1, `busy` = 0, `frame_done` = 0, state IDLE, counter 0. Combinational outputs are 0.

## Timing
- Acceptance cycle is 0.
- Cycle 1: start bit.
- Cycles 2 to `DATA_WIDTH`+1: data bits.
- Cycle `DATA_WIDTH`+2: parity bit, if enabled.
- Then `STOP_BITS` stop cycles.
- `busy` is high for 1 + `DATA_WIDTH` + `par_en` + `STOP_BITS` cycles. With the defaults this is 10, or 11 with parity.
- `frame_done` is high in the first IDLE cycle after the frame.
- Earliest next acceptance is that same cycle, so the next start bit follows one cycle later.
- `ser_load`/`ser_en` are combinational from the state and have no registered latency. The serializer must present bit 0 on `ser_data` in the cycle after `ser_load`.

## Structure
- Package `uart_tx_pkg` holds:
  - the state enum;
  - `PAR_EVEN` = 0 and `PAR_ODD` = 1;
  - localparams for `IDLE_LEVEL` = 1, `START_LEVEL` = 0, `STOP_LEVEL` = 1.
- Sub-module `parity_calc` takes `DATA_WIDTH` data and `par_typ`, and produces the parity bit combinationally. It is instantiated once.
- The next-state and output logic is a two-process FSM with a registered `tx_out`.

## Test plan
- 0xA5, `par_en` = 0: line reads 0,1,0,1,0,0,1,0,1,1 over cycles 1–10. `busy` is high for 10 cycles; `frame_done` is high at cycle 11.
- 0xA5, `par_en` = 1, even: parity bit 0 at cycle 10, stop at 11. 0x01 with odd parity gives parity 0; 0x01 with even parity gives 1.
- `STOP_BITS` = 2, 0xFF with no parity: `tx_out` is high on cycles 10 and 11 and `busy` is high for 11 cycles.
- `data_valid` pulsed at cycles 3 and 8 during a frame: no second `ser_load`; the frame is unchanged.
- `rst` at cycle 5 of a 0x3C frame: cycle 6 shows `tx_out` = 1 and `busy` = 0. A new 0x55 accepted at cycle 7 transmits correctly.
- Back-to-back: `data_valid` held high across two bytes 0x12 then 0x34. The second start bit is exactly 2 cycles after the first frame's stop bit.
